// File: rtl/pdm_frontend_if.sv
// Word-pair handshake between the PDM front end and the downstream decimation stage.
// The front end is the master: it drives both words and sample_valid, the consumer returns sample_ready.
interface pdm_frontend_if #(
   parameter int WORD_BITS = 8
);
   logic [WORD_BITS-1:0] left_data;
   logic [WORD_BITS-1:0] right_data;
   logic                 sample_valid;
   logic                 sample_ready;

   modport master (
      output left_data,
      output right_data,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  left_data,
      input  right_data,
      input  sample_valid,
      output sample_ready
   );
endinterface

// File: rtl/pdm_frontend.sv
// Stereo MEMS microphone front end: generates pdm_clk, synchronises the shared data line,
// splits it into left/right bit streams and hands packed word pairs downstream.
module pdm_frontend #(
   parameter int CLK_DIV        = 16,
   parameter int WAKEUP_PERIODS = 4096,
   parameter int WORD_BITS      = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic            pdm,
   output logic            pdm_clk_out,
   pdm_frontend_if.master  smp,
   output logic            overrun,
   input  logic            overrun_clr,
   output logic            running
);
   localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int WAKE_W = $clog2(WAKEUP_PERIODS + 1);
   localparam int BIT_W  = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
   localparam logic [DIV_W-1:0]  LEFT_PT   = DIV_W'(CLK_DIV / 2 - 1);
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKEUP_PERIODS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);

   typedef enum logic [1:0] {ST_OFF, ST_WAKEUP, ST_RUN} state_t;

   state_t                state_reg, state_next;
   logic                  pdm_meta_reg, pdm_s;
   logic [DIV_W-1:0]      div_cnt_reg, div_cnt_next;
   logic                  pdm_clk_reg, pdm_clk_next;
   logic [WAKE_W-1:0]     wake_cnt_reg;
   logic [BIT_W-1:0]      bit_cnt_reg;
   logic [WORD_BITS-1:0]  left_sr_reg, right_sr_reg;
   logic [WORD_BITS-1:0]  left_data_reg, right_data_reg;
   logic                  valid_reg, overrun_reg;
   logic                  div_wrap, active, left_pt, complete, accept;

   // Two-flop synchroniser for the asynchronous data line; deliberately left unreset.
   always_ff @(posedge clock) begin
      pdm_meta_reg <= pdm;
      pdm_s        <= pdm_meta_reg;
   end

   always_ff @(posedge clock) begin
      if (reset) state_reg <= ST_OFF;
      else       state_reg <= state_next;
   end

   assign div_wrap = (div_cnt_reg == DIV_LAST);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_OFF:    if (enable) state_next = ST_WAKEUP;
         ST_WAKEUP: if (div_wrap && wake_cnt_reg == WAKE_LAST) state_next = ST_RUN;
         ST_RUN:    state_next = ST_RUN;
         default:   state_next = ST_OFF;
      endcase
      if (!enable) state_next = ST_OFF;
   end

   // The divider restarts from 0 on leaving OFF, so pdm_clk_out begins with a full high phase.
   always_comb begin
      div_cnt_next = '0;
      if (state_reg != ST_OFF && state_next != ST_OFF && !div_wrap)
         div_cnt_next = div_cnt_reg + 1'b1;
      pdm_clk_next = (state_next != ST_OFF) && (div_cnt_next < DIV_HALF);
   end

   assign active   = (state_reg == ST_RUN) && enable;
   assign left_pt  = (div_cnt_reg == LEFT_PT);
   assign complete = active && div_wrap && (bit_cnt_reg == BIT_LAST);
   assign accept   = valid_reg && smp.sample_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt_reg    <= '0;
         pdm_clk_reg    <= 1'b0;
         wake_cnt_reg   <= '0;
         bit_cnt_reg    <= '0;
         left_sr_reg    <= '0;
         right_sr_reg   <= '0;
         left_data_reg  <= '0;
         right_data_reg <= '0;
         valid_reg      <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         div_cnt_reg <= div_cnt_next;
         pdm_clk_reg <= pdm_clk_next;

         if (state_reg != ST_WAKEUP) wake_cnt_reg <= '0;
         else if (div_wrap)          wake_cnt_reg <= wake_cnt_reg + 1'b1;

         // Outside active RUN every partial word is thrown away.
         if (!active) begin
            bit_cnt_reg  <= '0;
            left_sr_reg  <= '0;
            right_sr_reg <= '0;
         end else begin
            if (left_pt)
               left_sr_reg <= {left_sr_reg[WORD_BITS-2:0], pdm_s};
            if (div_wrap) begin
               right_sr_reg <= {right_sr_reg[WORD_BITS-2:0], pdm_s};
               bit_cnt_reg  <= (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
            end
         end

         if (complete) begin
            if (!valid_reg || smp.sample_ready) begin
               left_data_reg  <= left_sr_reg;
               right_data_reg <= {right_sr_reg[WORD_BITS-2:0], pdm_s};
               valid_reg      <= 1'b1;
            end
         end else if (accept) begin
            valid_reg <= 1'b0;
         end

         if (complete && valid_reg && !smp.sample_ready) overrun_reg <= 1'b1;
         else if (overrun_clr)                           overrun_reg <= 1'b0;
      end
   end

   assign pdm_clk_out      = pdm_clk_reg;
   assign smp.left_data    = left_data_reg;
   assign smp.right_data   = right_data_reg;
   assign smp.sample_valid = valid_reg;
   assign overrun          = overrun_reg;
   assign running          = (state_reg == ST_RUN);
endmodule
